// File: rtl/aud_pkg.sv
`default_nettype none
// ============================================================================
// aud_pkg -- shared audio player/recorder types and default sizes
// Revision: 1.0
// ============================================================================
package aud_pkg;

  localparam int AUD_DATA_W     = 16;
  localparam int AUD_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_PLAY  = 2'd2,
    S_PAUSE = 2'd3
  } aud_state_e;

endpackage
`default_nettype wire

// File: rtl/aud_sample_fifo.sv
`default_nettype none
// ============================================================================
// aud_sample_fifo -- small circular sample buffer with push/pop/flush
// Revision: 1.0
// ============================================================================
module aud_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // Pointers wrap modulo DEPTH so non-power-of-two depths work too
  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/aud_player_tx.sv
`default_nettype none
// ============================================================================
// aud_player_tx -- WM8731 DAC serializer with play/pause/stop control
// Revision: 1.0
// ============================================================================
module aud_player_tx
  import aud_pkg::*;
#(
  parameter int DATA_W     = AUD_DATA_W,
  parameter int FIFO_DEPTH = AUD_FIFO_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_dacdat,
  output logic              o_underrun,
  output logic [1:0]        o_state
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  aud_state_e        r_state;
  aud_state_e        w_state_nxt;
  logic              r_lrc;
  logic              r_pause_req;
  logic              r_start_req;
  logic              w_pause_req_nxt;
  logic              w_start_req_nxt;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bitcnt;
  logic              r_dacdat;
  logic              r_underrun;
  logic [DATA_W-1:0] w_fifo_data;
  logic [DATA_W-1:0] w_pop_data;
  logic [DATA_W-1:0] w_src;
  logic              w_edge;
  logic              w_frame;
  logic              w_pop;
  logic              w_xmit;
  logic              w_flush;
  logic              w_full;
  logic              w_empty;

  assign w_edge     = (i_lrc != r_lrc);
  assign w_frame    = r_lrc & ~i_lrc;
  assign o_ready    = (r_state != S_IDLE) && !w_full;
  assign w_pop_data = w_empty ? '0 : w_fifo_data;
  assign w_src      = w_pop ? w_pop_data : r_hold;
  assign o_dacdat   = r_dacdat;
  assign o_underrun = r_underrun;
  assign o_state    = r_state;

  aud_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_valid && o_ready),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (i_data),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pause_req <= 1'b0;
      r_start_req <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pause_req <= w_pause_req_nxt;
      r_start_req <= w_start_req_nxt;
    end
  end

  // An underrun pop leaves the state where it was so the next frame retries
  always_comb begin
    w_state_nxt     = r_state;
    w_pause_req_nxt = r_pause_req;
    w_start_req_nxt = r_start_req;
    w_pop           = 1'b0;
    w_xmit          = 1'b0;
    w_flush         = 1'b0;
    if (i_stop) begin
      w_state_nxt     = S_IDLE;
      w_flush         = 1'b1;
      w_pause_req_nxt = 1'b0;
      w_start_req_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) w_state_nxt = S_ARM;
        end
        S_ARM: begin
          if (w_frame) begin
            w_pop  = 1'b1;
            w_xmit = 1'b1;
            if (!w_empty) w_state_nxt = S_PLAY;
          end
        end
        S_PLAY: begin
          if (i_start)      w_pause_req_nxt = 1'b0;
          else if (i_pause) w_pause_req_nxt = 1'b1;
          if (w_frame && r_pause_req) begin
            w_state_nxt     = S_PAUSE;
            w_pause_req_nxt = 1'b0;
          end else begin
            w_xmit = w_edge;
            w_pop  = w_frame;
          end
        end
        S_PAUSE: begin
          if (i_start) w_start_req_nxt = 1'b1;
          if (w_frame && r_start_req) begin
            w_pop  = 1'b1;
            w_xmit = 1'b1;
            if (!w_empty) begin
              w_state_nxt     = S_PLAY;
              w_start_req_nxt = 1'b0;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lrc      <= 1'b0;
      r_hold     <= '0;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_dacdat   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_lrc      <= i_lrc;
      r_underrun <= w_pop & w_empty;
      if (w_pop) r_hold <= w_pop_data;
      // Any edge that does not start a slot silences the line (pause, truncation)
      if (i_stop || (w_edge && !w_xmit) || (!w_xmit && r_bitcnt == '0)) begin
        r_shift  <= '0;
        r_bitcnt <= '0;
        r_dacdat <= 1'b0;
      end else if (w_xmit) begin
        r_shift  <= {w_src[DATA_W-2:0], 1'b0};
        r_bitcnt <= CNT_W'(DATA_W - 1);
        r_dacdat <= w_src[DATA_W-1];
      end else begin
        r_shift  <= {r_shift[DATA_W-2:0], 1'b0};
        r_bitcnt <= r_bitcnt - CNT_W'(1);
        r_dacdat <= r_shift[DATA_W-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aud_player_tx.sv
`default_nettype none
// ============================================================================
// tb_aud_player_tx -- directed table-driven bench for aud_player_tx
// Revision: 1.0
// ============================================================================
module tb_aud_player_tx;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_lrc   = 1'b0;
  logic        i_start = 1'b0;
  logic        i_pause = 1'b0;
  logic        i_stop  = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_data  = '0;
  logic        o_ready;
  logic        o_dacdat;
  logic        o_underrun;
  logic [1:0]  o_state;

  int   checks    = 0;
  int   failures  = 0;
  int   half      = 32;
  int   phase_cnt = 0;
  logic lrc_prev  = 1'b0;
  logic is_edge   = 1'b0;
  logic is_frame  = 1'b0;

  typedef struct {
    logic        push;
    logic [15:0] data;
    logic [15:0] exp_word;
    logic        exp_und;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs [5];

  aud_player_tx #(
    .DATA_W     (16),
    .FIFO_DEPTH (2)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_lrc      (i_lrc),
    .i_start    (i_start),
    .i_pause    (i_pause),
    .i_stop     (i_stop),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_dacdat   (o_dacdat),
    .o_underrun (o_underrun),
    .o_state    (o_state)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one clock; pulses clear, LRC advances, returns at the sampling negedge
  task automatic step();
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_start = 1'b0;
    i_pause = 1'b0;
    i_stop  = 1'b0;
    lrc_prev = i_lrc;
    phase_cnt++;
    if (phase_cnt >= half) begin
      phase_cnt = 0;
      i_lrc = ~i_lrc;
    end
    is_edge  = (i_lrc != lrc_prev);
    is_frame = lrc_prev & ~i_lrc;
    @(negedge i_clk);
  endtask

  task automatic push(input logic [15:0] d);
    i_data  = d;
    i_valid = 1'b1;
    step();
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while (!is_frame && n < 200);
    if (!is_frame) begin
      checks++;
      failures++;
      $display("FAIL wait_frame: actual=timeout required=frame start");
    end
  endtask

  task automatic wait_edge();
    int n = 0;
    do begin
      step();
      n++;
    end while (!is_edge && n < 200);
    if (!is_edge) begin
      checks++;
      failures++;
      $display("FAIL wait_edge: actual=timeout required=lrc edge");
    end
  endtask

  // Starts in an edge cycle: collects nbits bits MSB first, then nzero idle cycles
  task automatic slot(input string name, input int nbits, input int nzero,
                      input logic [15:0] exp, input logic exp_und);
    logic [15:0] w;
    logic        u1;
    logic        u2;
    logic        tail_ok;
    w = '0; u1 = 1'b0; u2 = 1'b0; tail_ok = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      step();
      if (b == 0) u1 = o_underrun;
      if (b == 1) u2 = o_underrun;
      w = {w[14:0], o_dacdat};
    end
    for (int z = 0; z < nzero; z++) begin
      step();
      if (o_dacdat !== 1'b0) tail_ok = 1'b0;
    end
    check({name, ".word"}, 32'(w), 32'(exp));
    check({name, ".underrun"}, 32'(u1), 32'(exp_und));
    if (nbits > 1) check({name, ".pulse_len"}, 32'(u2), 32'd0);
    if (nzero > 0) check({name, ".tail_zero"}, 32'(tail_ok), 32'd1);
  endtask

  initial begin
    vecs[0] = '{push: 1'b0, data: 16'h0000, exp_word: 16'h0000, exp_und: 1'b1, exp_state: 2'd1};
    vecs[1] = '{push: 1'b1, data: 16'h8000, exp_word: 16'h8000, exp_und: 1'b0, exp_state: 2'd2};
    vecs[2] = '{push: 1'b1, data: 16'hA5C3, exp_word: 16'hA5C3, exp_und: 1'b0, exp_state: 2'd2};
    vecs[3] = '{push: 1'b1, data: 16'h0001, exp_word: 16'h0001, exp_und: 1'b0, exp_state: 2'd2};
    vecs[4] = '{push: 1'b1, data: 16'h7FFE, exp_word: 16'h7FFE, exp_und: 1'b0, exp_state: 2'd2};

    // Reset values
    for (int i = 0; i < 3; i++) step();
    check("rst.state", 32'(o_state), 32'd0);
    check("rst.dacdat", 32'(o_dacdat), 32'd0);
    check("rst.underrun", 32'(o_underrun), 32'd0);
    check("rst.ready", 32'(o_ready), 32'd0);
    i_rst_n = 1'b1;
    step();

    // Idle: no acceptance, pause ignored, start arms
    i_valid = 1'b1;
    i_data  = 16'hDEAD;
    check("idle.ready", 32'(o_ready), 32'd0);
    step();
    i_pause = 1'b1;
    step();
    check("idle.pause_ignored", 32'(o_state), 32'd0);
    i_start = 1'b1;
    step();
    check("arm.state", 32'(o_state), 32'd1);
    check("arm.ready", 32'(o_ready), 32'd1);

    // Table: one sample per frame, mono in both slots
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].push) push(vecs[i].data);
      wait_frame();
      slot($sformatf("vec%0d.L", i), 16, 8, vecs[i].exp_word, vecs[i].exp_und);
      check($sformatf("vec%0d.state", i), 32'(o_state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d.ready", i), 32'(o_ready), 32'd1);
      wait_edge();
      slot($sformatf("vec%0d.R", i), 16, 8, vecs[i].exp_word, 1'b0);
    end

    // Full buffer: third sample refused, order kept, then underrun in play
    push(16'h1111);
    push(16'h2222);
    check("full.ready", 32'(o_ready), 32'd0);
    i_data  = 16'h3333;
    i_valid = 1'b1;
    step();
    check("full.ready_hold", 32'(o_ready), 32'd0);
    wait_frame();
    slot("full.L0", 16, 8, 16'h1111, 1'b0);
    check("full.ready_after_pop", 32'(o_ready), 32'd1);
    wait_edge();
    slot("full.R0", 16, 8, 16'h1111, 1'b0);
    wait_frame();
    slot("full.L1", 16, 8, 16'h2222, 1'b0);
    wait_edge();
    slot("full.R1", 16, 8, 16'h2222, 1'b0);
    wait_frame();
    slot("play_underrun.L", 16, 8, 16'h0000, 1'b1);
    check("play_underrun.state", 32'(o_state), 32'd2);

    // Pause mid-frame, resume with the next buffered sample
    push(16'hFFFF);
    push(16'h5555);
    wait_frame();
    slot("pause.L0", 16, 8, 16'hFFFF, 1'b0);
    i_pause = 1'b1;
    step();
    wait_edge();
    slot("pause.R0", 16, 8, 16'hFFFF, 1'b0);
    wait_frame();
    slot("pause.L1", 16, 8, 16'h0000, 1'b0);
    check("pause.state", 32'(o_state), 32'd3);
    check("pause.ready", 32'(o_ready), 32'd1);
    wait_edge();
    slot("pause.R1", 16, 8, 16'h0000, 1'b0);
    i_start = 1'b1;
    step();
    wait_frame();
    slot("resume.L", 16, 8, 16'h5555, 1'b0);
    check("resume.state", 32'(o_state), 32'd2);
    wait_edge();
    slot("resume.R", 16, 8, 16'h5555, 1'b0);

    // Stop at bit 5 with start/pause in the same cycle; buffer is flushed
    push(16'hFFFF);
    push(16'h1234);
    wait_frame();
    slot("stop.bits", 5, 0, 16'h001F, 1'b0);
    i_stop  = 1'b1;
    i_start = 1'b1;
    i_pause = 1'b1;
    step();
    check("stop.dacdat", 32'(o_dacdat), 32'd0);
    check("stop.state", 32'(o_state), 32'd0);
    check("stop.ready", 32'(o_ready), 32'd0);
    step();
    step();
    check("stop.stays_idle", 32'(o_state), 32'd0);
    i_start = 1'b1;
    step();
    check("restart.state", 32'(o_state), 32'd1);
    wait_frame();
    slot("flush.L", 16, 8, 16'h0000, 1'b1);

    // Short LRC slots: truncated, MSB restarts at every edge
    half      = 10;
    phase_cnt = 0;
    push(16'hC3A5);
    push(16'hFFFF);
    wait_frame();
    slot("fast.L", 9, 0, 16'h0187, 1'b0);
    step();
    slot("fast.R", 9, 0, 16'h0187, 1'b0);
    step();
    slot("fast.L2", 3, 0, 16'h0007, 1'b0);

    // Asynchronous reset in the middle of a slot of ones
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_rst.dacdat", 32'(o_dacdat), 32'd0);
    check("async_rst.state", 32'(o_state), 32'd0);
    step();
    step();
    i_rst_n = 1'b1;
    step();
    step();
    check("post_rst.state", 32'(o_state), 32'd0);
    check("post_rst.ready", 32'(o_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
